// File: rtl/secuenciador_teclado_pkg.sv
// Shared definitions for the keypad entry sequencer: key codes, the
// debouncer FSM encoding and small key-classification helpers.
package teclado_pkg;

    // Scanner codes above the 0-15 key range
    localparam logic [4:0] KEY_NONE    = 5'd16;
    localparam logic [4:0] KEY_INVALID = 5'd17;

    // Function keys inside the 0-15 range
    localparam logic [3:0] KEY_BORRAR  = 4'hE;
    localparam logic [3:0] KEY_ENTER   = 4'hF;

    // Debouncer / release-detector states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } estado_t;

    // A scanner code is a real key only below KEY_NONE; KEY_INVALID and
    // anything else above counts as "no key".
    function automatic logic es_tecla(input logic [4:0] code);
        return (code < KEY_NONE);
    endfunction

    // Decimal digit keys 0-9
    function automatic logic es_digito(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/secuenciador_teclado_if.sv
// Keypad sequencer bus: scanner code and consumer handshake in, entry
// buffer, committed value and event pulses out.
// master = sequencer side, slave = scanner/consumer side.
interface secuenciador_teclado_if #(
    parameter int N_DIG = 3
);
    localparam int NW = $clog2(N_DIG + 1);

    logic [4:0]         digito;
    logic               valor_rdy;
    logic [4*N_DIG-1:0] bcd;
    logic [NW-1:0]      n_dig;
    logic [4*N_DIG-1:0] valor;
    logic               valor_vld;
    logic               tecla_evt;
    logic               error;

    modport master (
        input  digito, valor_rdy,
        output bcd, n_dig, valor, valor_vld, tecla_evt, error
    );

    modport slave (
        output digito, valor_rdy,
        input  bcd, n_dig, valor, valor_vld, tecla_evt, error
    );

endinterface

// File: rtl/secuenciador_teclado_antirrebote.sv
// antirrebote_tecla: debounces the scanner code and waits for the key to
// be released before arming again. Emits the accepted 4-bit code with a
// one-cycle strobe that is high during the ACCEPT state.
module antirrebote_tecla
    import teclado_pkg::*;
#(
    parameter int DEB_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] digito,
    output logic [3:0] codigo,
    output logic       strobe
);

    localparam int            CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    estado_t       estado_r, estado_s;
    logic [CW-1:0] cuenta_r, cuenta_s;
    logic [3:0]    codigo_r, codigo_s;
    logic          strobe_r, strobe_s;
    logic          tecla_s;

    assign tecla_s = es_tecla(digito);

    // Next-state logic: count identical key samples, then identical no-key samples
    always_comb begin
        estado_s = estado_r;
        cuenta_s = cuenta_r;
        codigo_s = codigo_r;
        strobe_s = 1'b0;
        case (estado_r)
            ST_IDLE: begin
                if (tecla_s) begin
                    codigo_s = digito[3:0];
                    if (CNT_LAST == '0) begin
                        estado_s = ST_ACCEPT;
                        strobe_s = 1'b1;
                        cuenta_s = '0;
                    end else begin
                        estado_s = ST_DEBOUNCE;
                        cuenta_s = CW'(1);
                    end
                end else begin
                    cuenta_s = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!tecla_s) begin
                    estado_s = ST_IDLE;
                    cuenta_s = '0;
                end else if (digito[3:0] != codigo_r) begin
                    // A different key restarts the count with the new code
                    codigo_s = digito[3:0];
                    cuenta_s = CW'(1);
                end else if (cuenta_r == CNT_LAST) begin
                    estado_s = ST_ACCEPT;
                    strobe_s = 1'b1;
                    cuenta_s = '0;
                end else begin
                    cuenta_s = cuenta_r + CW'(1);
                end
            end
            ST_ACCEPT: begin
                estado_s = ST_WAIT_REL;
                cuenta_s = '0;
            end
            ST_WAIT_REL: begin
                if (tecla_s) begin
                    cuenta_s = '0;
                end else if (cuenta_r == CNT_LAST) begin
                    estado_s = ST_IDLE;
                    cuenta_s = '0;
                end else begin
                    cuenta_s = cuenta_r + CW'(1);
                end
            end
            default: begin
                estado_s = ST_IDLE;
                cuenta_s = '0;
            end
        endcase
    end

    // State, counter, captured code and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= ST_IDLE;
            cuenta_r <= '0;
            codigo_r <= 4'h0;
            strobe_r <= 1'b0;
        end else begin
            estado_r <= estado_s;
            cuenta_r <= cuenta_s;
            codigo_r <= codigo_s;
            strobe_r <= strobe_s;
        end
    end

    assign codigo = codigo_r;
    assign strobe = strobe_r;

endmodule

// File: rtl/secuenciador_teclado.sv
// secuenciador_teclado: keypad entry sequencer. Debounced keys build a BCD
// entry (newest digit in the low nibble); 0xE deletes the newest digit,
// 0xF commits the entry to valor with a valid/ready handshake.
// Optional build macro TECLADO_TIMEOUT_EN adds an idle auto-clear of the
// entry after TIMEOUT_CNT cycles without a key.
module secuenciador_teclado
    import teclado_pkg::*;
#(
    parameter int DEB_CNT     = 3,
    parameter int N_DIG       = 3,
    parameter int TIMEOUT_CNT = 500
) (
    input logic                   clk,
    input logic                   rst_n,
    secuenciador_teclado_if.master bus
);

    localparam int            BW     = 4 * N_DIG;
    localparam int            NW     = $clog2(N_DIG + 1);
    localparam logic [NW-1:0] N_FULL = NW'(N_DIG);

    logic [3:0]    tecla_cod_s;
    logic          tecla_stb_s;
    logic          timeout_s;

    logic [BW-1:0] bcd_r, bcd_s;
    logic [NW-1:0] n_dig_r, n_dig_s;
    logic [BW-1:0] valor_r, valor_s;
    logic          valor_vld_r, valor_vld_s;
    logic          error_r, error_s;

    antirrebote_tecla #(
        .DEB_CNT (DEB_CNT)
    ) u_antirrebote (
        .clk    (clk),
        .rst_n  (rst_n),
        .digito (bus.digito),
        .codigo (tecla_cod_s),
        .strobe (tecla_stb_s)
    );

`ifdef TECLADO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CNT + 1);
    logic [TW-1:0] inactivo_r;

    assign timeout_s = (inactivo_r == TW'(TIMEOUT_CNT));

    // Idle counter: restarts on every accepted key, saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inactivo_r <= '0;
        end else if (tecla_stb_s) begin
            inactivo_r <= '0;
        end else if (timeout_s) begin
            inactivo_r <= inactivo_r;
        end else begin
            inactivo_r <= inactivo_r + TW'(1);
        end
    end
`else
    // Parameter kept so both builds share one parameter list
    localparam int timeout_cnt_unused = TIMEOUT_CNT;

    assign timeout_s = 1'b0;
`endif

    // Entry buffer and commit handshake next-state logic
    always_comb begin
        bcd_s       = bcd_r;
        n_dig_s     = n_dig_r;
        valor_s     = valor_r;
        error_s     = 1'b0;
        if (valor_vld_r && bus.valor_rdy) begin
            valor_vld_s = 1'b0;
        end else begin
            valor_vld_s = valor_vld_r;
        end

        if (tecla_stb_s) begin
            case (tecla_cod_s)
                KEY_BORRAR: begin
                    // Deleting from an empty entry is silently ignored
                    if (n_dig_r != '0) begin
                        bcd_s   = bcd_r >> 4;
                        n_dig_s = n_dig_r - NW'(1);
                    end else begin
                        bcd_s   = bcd_r;
                    end
                end
                KEY_ENTER: begin
                    // Commit only a non-empty entry and never overwrite a pending one
                    if ((n_dig_r != '0) && !valor_vld_r) begin
                        valor_s     = bcd_r;
                        valor_vld_s = 1'b1;
                        bcd_s       = '0;
                        n_dig_s     = '0;
                    end else begin
                        error_s     = 1'b1;
                    end
                end
                default: begin
                    if (es_digito(tecla_cod_s)) begin
                        if (n_dig_r != N_FULL) begin
                            bcd_s   = BW'({bcd_r, tecla_cod_s});
                            n_dig_s = n_dig_r + NW'(1);
                        end else begin
                            error_s = 1'b1;
                        end
                    end else begin
                        // Keys 0xA-0xD only produce the event pulse
                        bcd_s = bcd_r;
                    end
                end
            endcase
        end else if (timeout_s && (n_dig_r != '0)) begin
            bcd_s   = '0;
            n_dig_s = '0;
        end else begin
            bcd_s   = bcd_r;
        end
    end

    // Entry, committed value and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r       <= '0;
            n_dig_r     <= '0;
            valor_r     <= '0;
            valor_vld_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            bcd_r       <= bcd_s;
            n_dig_r     <= n_dig_s;
            valor_r     <= valor_s;
            valor_vld_r <= valor_vld_s;
            error_r     <= error_s;
        end
    end

    assign bus.bcd       = bcd_r;
    assign bus.n_dig     = n_dig_r;
    assign bus.valor     = valor_r;
    assign bus.valor_vld = valor_vld_r;
    assign bus.tecla_evt = tecla_stb_s;
    assign bus.error     = error_r;

endmodule

// File: doc/secuenciador_teclado.md
SECUENCIADOR_TECLADO -- requirements
Module: secuenciador_teclado

Interface
REQ-001 Parameter DEB_CNT, default 3, meaning consecutive identical samples required to accept a key.
REQ-002 Parameter N_DIG, default 3, meaning maximum decimal digits per entry.
REQ-003 Parameter TIMEOUT_CNT, default 500, meaning idle cycles before auto-clear (TECLADO_TIMEOUT_EN only).
REQ-004 clk  input  1  single system clock, 100 Hz scan clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 digito  input  5  scanner key code: 0-15 key, 16 no key, 17 invalid column.
REQ-007 valor_rdy  input  1  consumer accepts valor when high with valor_vld.
REQ-008 bcd  output  4*N_DIG  current entry, BCD, newest digit in bits [3:0].
REQ-009 n_dig  output  clog2(N_DIG+1)  digits currently held.
REQ-010 valor  output  4*N_DIG  committed entry, stable while valor_vld is high.
REQ-011 valor_vld  output  1  committed entry available.
REQ-012 tecla_evt  output  1  one-cycle pulse per accepted key.
REQ-013 error  output  1  one-cycle pulse on a rejected key action.

Function
REQ-014 Debounce: a code 0-15 is accepted when it has been sampled unchanged for DEB_CNT consecutive cycles.
REQ-015 A code change during debounce shall restart the count with the new code.
REQ-016 After acceptance, no further key shall be accepted until codes >=16 have been seen for DEB_CNT consecutive cycles (release).
REQ-017 FSM states: IDLE (no key), DEBOUNCE (counting), ACCEPT (one cycle, action executed), WAIT_REL (waiting for release).
REQ-018 Transitions: IDLE->DEBOUNCE on code<16; DEBOUNCE->IDLE on code>=16; DEBOUNCE->ACCEPT at count DEB_CNT; ACCEPT->WAIT_REL always; WAIT_REL->IDLE after release.
REQ-019 tecla_evt shall pulse in the ACCEPT cycle, one cycle after the final debounce sample.
REQ-020 Digit 0-9 with n_dig<N_DIG: bcd shifts left 4, digit enters [3:0], n_dig increments.
REQ-021 Digit 0-9 with n_dig==N_DIG: entry unchanged, error pulses.
REQ-022 Key 0xE (borrar): bcd shifts right 4 with zero fill, n_dig decrements; at n_dig==0, no change and no error.
REQ-023 Key 0xF (enter) with n_dig>0 and valor_vld low: valor<=bcd, valor_vld<=1, bcd<=0, n_dig<=0, all in the cycle after ACCEPT.
REQ-024 Key 0xF with n_dig==0 or valor_vld high: entry unchanged, error pulses.
REQ-025 Keys 0xA-0xD: tecla_evt pulses, entry unchanged, no error.
REQ-026 valor_vld shall stay high, with valor stable, until a cycle with valor_rdy high, then clear next cycle.
REQ-027 Code 17 shall be treated as no key.

Reset
REQ-028 rst_n low shall asynchronously force state IDLE, all counters 0, bcd 0, n_dig 0, valor 0, valor_vld 0, tecla_evt 0, error 0.
REQ-029 Reset mid-debounce or mid-handshake shall discard the pending key and the pending valor.

Configuration
REQ-030 With TECLADO_TIMEOUT_EN defined, an idle counter shall reset on every tecla_evt; when it reaches TIMEOUT_CNT with n_dig>0, bcd and n_dig shall clear without error.
REQ-031 Without TECLADO_TIMEOUT_EN, no idle counter shall exist and the entry shall persist indefinitely.

Structure
REQ-032 Package teclado_pkg shall hold KEY_NONE=16, KEY_INVALID=17, KEY_BORRAR=4'hE, KEY_ENTER=4'hF and the FSM state encoding.
REQ-033 Debounce plus release detection shall be sub-module antirrebote_tecla (outputs accepted code plus one-cycle strobe); entry buffer and handshake stay in the top.

Verification
REQ-034 Hold digito=5 for 3 cycles -> tecla_evt one pulse on cycle 4, bcd=...005, n_dig=1; holding 10 more cycles -> no second pulse.
REQ-035 Sequence 1,2,3 (release between each), then 4 -> bcd=0x123, n_dig=3, error pulse on key 4, bcd unchanged.
REQ-036 Entry 0x123, press F with valor_rdy=0 -> valor=0x123, valor_vld held high, bcd=0; press F again -> error; raise valor_rdy -> valor_vld clears next cycle.
REQ-037 Digito 7,7,8,8,8 -> exactly one accept with code 8; entry 0x12 then E -> bcd=0x001, n_dig=1.
REQ-038 Drop rst_n during DEBOUNCE with valor_vld high -> all outputs 0 immediately, no tecla_evt after release.
REQ-039 With TECLADO_TIMEOUT_EN, TIMEOUT_CNT=10: enter digit 9, idle 10 cycles -> bcd=0, n_dig=0, error stays low.
